// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

  localparam logic [XLEN-1:0] PC_INCR = 32'd4;
  localparam logic [XLEN-1:0] NOP     = 32'h0000_0000;

  // Payload carried by the IF/ID register and the skid buffer.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{instr: NOP, pc_plus4: '0};

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, hold, or kill (clear valid while data holds).
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   kill_i,
  input  if_id_t data_i,
  output logic   valid_o,
  output if_id_t data_o
);

  logic   valid_q;
  if_id_t data_q;

  // kill takes priority over load; neither means hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= IF_ID_RESET;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, an imem request FSM with a one-word
// skid buffer for words that land during a stall, and the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       skid_q, skid_d;

  logic   fetch_done;
  logic   id_load;
  logic   id_kill;
  if_id_t id_data;
  if_id_t id_out;

  assign pc_plus4   = pc_q + PC_INCR;
  assign imem_addr  = pc_q;
  assign imem_req   = ~rst & (state_q == ST_REQ);
  assign fetch_done = imem_req & imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      skid_q  <= IF_ID_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
    end
  end

  // Redirect beats stall; a word landing under stall is parked until release.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skid_d  = skid_q;
    id_load = 1'b0;
    id_kill = 1'b0;
    id_data = '{instr: imem_rdata, pc_plus4: pc_plus4};

    if (pc_src) begin
      pc_d    = next_pc;
      id_kill = 1'b1;
      skid_d  = IF_ID_RESET;
      state_d = ST_REQ;
    end else if (stall) begin
      if (fetch_done) begin
        skid_d  = '{instr: imem_rdata, pc_plus4: pc_plus4};
        state_d = ST_HOLD;
      end
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (fetch_done) begin
            id_load = 1'b1;
            pc_d    = next_pc;
          end else begin
            id_kill = 1'b1;
          end
        end
        ST_HOLD: begin
          id_load = 1'b1;
          id_data = skid_q;
          pc_d    = next_pc;
          state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (id_load),
    .kill_i  (id_kill),
    .data_i  (id_data),
    .valid_o (if_valid),
    .data_o  (id_out)
  );

  assign if_instr    = id_out.instr;
  assign if_pc_plus4 = id_out.pc_plus4;

endmodule
